// File: rtl/fpu_seq_pkg.sv
// ---------------------------------------------------------------------------
// fpu_seq_pkg
// Shared definitions for the FPU ALU issue sequencer:
//   - ALU operation encodings
//   - response flag bit positions
//   - sequencer FSM state encoding
//   - the queued request record (op + two IEEE-754 single operands)
// ---------------------------------------------------------------------------
package fpu_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;   // a - b
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;   // a / b

    localparam int FLG_UDF = 0;
    localparam int FLG_OVF = 1;
    localparam int FLG_EXC = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/fpu_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_alu_sequencer_if
// Bundles the three channels around the sequencer:
//   req_*  : valid/ready request channel (operands + op)
//   alu_*  : registered operands out to the combinational ALU, result/flags back
//   rsp_*  : valid/ready registered response channel
// Modports:
//   slave  : the sequencer itself
//   master : the surrounding system (requester, ALU, response consumer)
// ---------------------------------------------------------------------------
interface fpu_alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;

    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [1:0]  alu_oper;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        alu_underflow;
    logic        alu_exception;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic [1:0]  rsp_op;

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready,
        output alu_input1, alu_input2, alu_oper,
        input  alu_result, alu_overflow, alu_underflow, alu_exception,
        output rsp_valid, rsp_result, rsp_flags, rsp_op,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready,
        input  alu_input1, alu_input2, alu_oper,
        output alu_result, alu_overflow, alu_underflow, alu_exception,
        input  rsp_valid, rsp_result, rsp_flags, rsp_op,
        output rsp_ready
    );

endinterface

// File: rtl/fpu_req_fifo.sv
// ---------------------------------------------------------------------------
// fpu_req_fifo
// Small request queue, DEPTH entries (power of two) of WIDTH bits.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write one entry (caller guarantees !full)
//   pop, pop_data       : pop_data shows the head; pop advances it
//   full, empty, count  : occupancy, all from the registered count
// ---------------------------------------------------------------------------
module fpu_req_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == FULL_CNT);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule

// File: rtl/fpu_alu_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_alu_sequencer
// Issue stage in front of a combinational IEEE-754 single-precision ALU.
// Requests are queued, then issued one at a time: operands are registered
// onto the ALU inputs, held for SETTLE_CYCLES, and the ALU result and flags
// are captured into a registered response that is held until consumed.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : req_* request channel, alu_* ALU bus, rsp_* response
//   sticky_clr    : clears the accumulated flags
//   sticky_flags  : OR of every captured rsp_flags since reset/clear
//   busy          : FSM not idle
// ---------------------------------------------------------------------------
module fpu_alu_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fpu_alu_sequencer_if.slave     bus,
    input  logic                   sticky_clr,
    output logic [2:0]             sticky_flags,
    output logic                   busy
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]              SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [$clog2(DEPTH):0]     FULL_CNT    = ($clog2(DEPTH)+1)'(DEPTH);

    state_e              r_state;
    logic [CW-1:0]       r_cnt;
    logic [31:0]         r_alu_a;
    logic [31:0]         r_alu_b;
    logic [1:0]          r_alu_op;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_result;
    logic [2:0]          r_rsp_flags;
    logic [1:0]          r_rsp_op;

    req_t                w_push_data;
    req_t                w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                w_capture;
    logic [2:0]          w_cap_flags;

    // req_ready is a function of the registered count only, so a pop in the
    // same cycle never opens a slot for a push while full.
    assign bus.req_ready = (w_count != FULL_CNT);
    assign w_push        = bus.req_valid && !w_full;
    assign w_push_data   = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};

    // Operands are loaded from the head either out of IDLE or straight out
    // of HOLD when the current response is consumed.
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && bus.rsp_ready));

    fpu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign w_capture              = (r_state == ST_SETTLE) && (r_cnt == CW'(1));
    assign w_cap_flags[FLG_UDF]   = bus.alu_underflow;
    assign w_cap_flags[FLG_OVF]   = bus.alu_overflow;
    assign w_cap_flags[FLG_EXC]   = bus.alu_exception;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_op     <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
                r_alu_op <= w_head.op;
                r_cnt    <= SETTLE_LOAD;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_capture) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_flags  <= w_cap_flags;
                        r_rsp_op     <= r_alu_op;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_pop ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Clear drops the old bits but a capture on the same edge still lands.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
        logic r_bit;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_bit <= 1'b0;
            end else if (w_capture) begin
                r_bit <= w_cap_flags[gi] | (r_bit & ~sticky_clr);
            end else if (sticky_clr) begin
                r_bit <= 1'b0;
            end
        end
        assign sticky_flags[gi] = r_bit;
    end

    assign bus.alu_input1 = r_alu_a;
    assign bus.alu_input2 = r_alu_b;
    assign bus.alu_oper   = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_op     = r_rsp_op;
    assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_alu_sequencer
// Bench for fpu_alu_sequencer. A stand-in ALU answers the directed float
// vectors with their true IEEE-754 results and everything else with a hash.
// The reference keeps request/expected queues and a sticky-flag word.
// ---------------------------------------------------------------------------
module tb_fpu_alu_sequencer;
    import fpu_seq_pkg::*;

    localparam int DEPTH = 4;
    localparam int SC    = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } treq_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [2:0] sticky_flags;
    logic       busy;

    fpu_alu_sequencer_if bus ();

    fpu_alu_sequencer #(.DEPTH(DEPTH), .SETTLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .sticky_clr   (sticky_clr),
        .sticky_flags (sticky_flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Returns {exc, ovf, udf, result}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [31:0] r;
        logic [2:0]  f;
        case ({op, a, b})
            {OP_ADD, 32'h3F800000, 32'h40000000}: begin r = 32'h40400000; f = 3'b000; end
            {OP_SUB, 32'h3F800000, 32'h40000000}: begin r = 32'hBF800000; f = 3'b000; end
            {OP_MUL, 32'h40000000, 32'h40400000}: begin r = 32'h40C00000; f = 3'b000; end
            {OP_DIV, 32'h40C00000, 32'h40000000}: begin r = 32'h40400000; f = 3'b000; end
            {OP_ADD, 32'h3F800000, 32'h3F800000}: begin r = 32'h40000000; f = 3'b000; end
            {OP_MUL, 32'h7F7FFFFF, 32'h40000000}: begin r = 32'h7F800000; f = 3'b010; end
            default: begin
                r = (a * 32'd3) ^ {b[15:0], b[31:16]} ^ {30'd0, op};
                f = r[2:0] ^ b[31:29];
            end
        endcase
        return {f, r};
    endfunction

    logic [34:0] alu_out;
    assign alu_out           = alu_f(bus.alu_input1, bus.alu_input2, bus.alu_oper);
    assign bus.alu_result    = alu_out[31:0];
    assign bus.alu_underflow = alu_out[32];
    assign bus.alu_overflow  = alu_out[33];
    assign bus.alu_exception = alu_out[34];

    int    checks = 0;
    int    errors = 0;
    int    ecount = 0;
    treq_t pend[$];
    treq_t expq[$];
    int    acc_edge[$];
    int    rise_edge[$];
    logic [2:0] sticky_m = 3'b000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic treq_t rnd_req();
        treq_t t;
        t.a  = $urandom;
        t.b  = $urandom;
        t.op = 2'($urandom_range(0, 3));
        return t;
    endfunction

    function automatic treq_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        treq_t t;
        t.a = a; t.b = b; t.op = op;
        return t;
    endfunction

    // One clock: offer the next pending request, advance, then update the
    // reference and check any freshly captured response and the sticky word.
    task automatic step();
        logic consume, accept, clr_was, prev_valid, rise;
        logic [34:0] e;
        consume = bus.rsp_valid && bus.rsp_ready;
        if (pend.size() > 0) begin
            bus.req_valid = 1'b1;
            bus.req_a     = pend[0].a;
            bus.req_b     = pend[0].b;
            bus.req_op    = pend[0].op;
        end else begin
            bus.req_valid = 1'b0;
        end
        accept     = bus.req_valid && bus.req_ready;
        clr_was    = sticky_clr;
        prev_valid = bus.rsp_valid;
        @(posedge clk);
        #1;
        ecount++;
        bus.req_valid = 1'b0;
        if (consume) void'(expq.pop_front());
        if (accept) begin
            expq.push_back(pend.pop_front());
            acc_edge.push_back(ecount);
        end
        rise = bus.rsp_valid && !prev_valid;
        if (rise) begin
            rise_edge.push_back(ecount);
            if (expq.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = alu_f(expq[0].a, expq[0].b, expq[0].op);
                chk("rsp_result", bus.rsp_result, e[31:0]);
                chk("rsp_flags", bus.rsp_flags, e[34:32]);
                chk("rsp_op", bus.rsp_op, expq[0].op);
                sticky_m = (clr_was ? 3'b000 : sticky_m) | e[34:32];
            end
        end else if (clr_was) begin
            sticky_m = 3'b000;
        end
        chk("sticky", sticky_flags, sticky_m);
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((pend.size() > 0 || expq.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk(tag, (pend.size() == 0 && expq.size() == 0 && !busy), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold_res, hold_a, hold_b;
        logic [2:0]  hold_f;
        logic        stable;
        int          n, rel;

        bus.req_valid = 1'b1;
        bus.req_a     = 32'h12345678;
        bus.req_b     = 32'h9ABCDEF0;
        bus.req_op    = OP_MUL;
        bus.rsp_ready = 1'b0;

        // Reset state, with a request offered throughout reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_in1", bus.alu_input1, 0);
        chk("rst_alu_in2", bus.alu_input2, 0);
        chk("rst_alu_oper", bus.alu_oper, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_rsp_op", bus.rsp_op, 0);
        chk("rst_sticky", sticky_flags, 0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_idle", busy, 0);

        // Single add: latency and operand drive
        acc_edge.delete(); rise_edge.delete();
        pend.push_back(mk(32'h3F800000, 32'h40000000, OP_ADD));
        step();
        step();
        chk("single_alu_in1", bus.alu_input1, 32'h3F800000);
        chk("single_alu_in2", bus.alu_input2, 32'h40000000);
        chk("single_alu_oper", bus.alu_oper, OP_ADD);
        chk("single_busy", busy, 1);
        chk("single_early_valid", bus.rsp_valid, 0);
        step();
        chk("single_early_valid2", bus.rsp_valid, 0);
        step();
        chk("single_valid", bus.rsp_valid, 1);
        chk("single_latency", (rise_edge.size() == 1) ? rise_edge[0] - acc_edge[0] : -1, 1 + SC);
        bus.rsp_ready = 1'b1;
        step();
        chk("single_consumed", bus.rsp_valid, 0);
        chk("single_idle", busy, 0);

        // Back-to-back burst with rsp_ready high
        acc_edge.delete(); rise_edge.delete();
        pend.push_back(mk(32'h3F800000, 32'h40000000, OP_SUB));
        pend.push_back(mk(32'h40000000, 32'h40400000, OP_MUL));
        pend.push_back(mk(32'h40C00000, 32'h40000000, OP_DIV));
        pend.push_back(mk(32'h3F800000, 32'h3F800000, OP_ADD));
        run_until_idle(60, "burst_drain");
        chk("burst_count", rise_edge.size(), 4);
        for (int i = 1; i < 4; i++) begin
            if (i < rise_edge.size())
                chk("burst_spacing", rise_edge[i] - rise_edge[i-1], SC + 1);
        end

        // Backpressure: stall with a second request queued
        acc_edge.delete(); rise_edge.delete();
        bus.rsp_ready = 1'b0;
        pend.push_back(rnd_req());
        pend.push_back(rnd_req());
        n = 0;
        while (!bus.rsp_valid && n < 20) begin step(); n++; end
        chk("bp_first_valid", bus.rsp_valid, 1);
        hold_res = bus.rsp_result; hold_f = bus.rsp_flags;
        hold_a = bus.alu_input1;   hold_b = bus.alu_input2;
        stable = 1'b1;
        repeat (10) begin
            step();
            if (bus.rsp_result !== hold_res || bus.rsp_flags !== hold_f ||
                bus.alu_input1 !== hold_a || bus.alu_input2 !== hold_b || bus.rsp_valid !== 1'b1)
                stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        chk("bp_queued", expq.size(), 2);
        bus.rsp_ready = 1'b1;
        step();
        rel = ecount;
        run_until_idle(40, "bp_drain");
        chk("bp_second_latency", (rise_edge.size() == 2) ? rise_edge[1] - rel : -1, SC);

        // Overflow flag, sticky accumulation and clear
        acc_edge.delete(); rise_edge.delete();
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        pend.push_back(mk(32'h7F7FFFFF, 32'h40000000, OP_MUL));
        pend.push_back(mk(32'h3F800000, 32'h40000000, OP_ADD));
        run_until_idle(40, "ovf_drain");
        chk("ovf_rsp_count", rise_edge.size(), 2);
        chk("ovf_sticky_kept", sticky_flags, 3'b010);
        chk("ovf_last_flags", bus.rsp_flags, 3'b000);
        sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
        chk("ovf_sticky_cleared", sticky_flags, 3'b000);

        // Full FIFO with response stalled
        acc_edge.delete(); rise_edge.delete();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) pend.push_back(rnd_req());
        repeat (12) step();
        chk("full_accepted", expq.size(), DEPTH + 1);
        chk("full_req_ready", bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        run_until_idle(100, "full_drain");
        chk("full_rsp_count", rise_edge.size(), DEPTH + 2);

        // Reset in the middle of SETTLE
        acc_edge.delete(); rise_edge.delete();
        bus.rsp_ready = 1'b0;
        pend.push_back(mk(32'h3F800000, 32'h40000000, OP_ADD));
        step();
        step();
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_in1", bus.alu_input1, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        expq.delete(); pend.delete(); sticky_m = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (8) step();
        chk("mid_no_rsp", rise_edge.size(), 0);
        pend.push_back(mk(32'h3F800000, 32'h3F800000, OP_ADD));
        run_until_idle(30, "mid_after_drain");
        chk("mid_after_count", rise_edge.size(), 1);

        // Randomized traffic, backpressure and sticky clears
        acc_edge.delete(); rise_edge.delete();
        for (int i = 0; i < 30; i++) pend.push_back(rnd_req());
        n = 0;
        while ((pend.size() > 0 || expq.size() > 0 || busy) && n < 600) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            sticky_clr    = ($urandom_range(0, 7) == 0);
            step();
            n++;
        end
        sticky_clr    = 1'b0;
        bus.rsp_ready = 1'b1;
        run_until_idle(60, "rand_drain");
        chk("rand_count", rise_edge.size(), 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
